usb_rx_sequencer: RTL and testbench
===================================

Name: usb_rx_sequencer

Overview:
- Receive-path controller between the DP/DM line sampler and the NRZI decoder output.
- Tells the NRZI decoder when a packet is on the wire (dpdm_sending), then checks SYNC, removes stuffed bits and detects EOP.
- Delivers a qualified decoded bit stream with packet start/end and error strobes to the downstream receive stages (PID/CRC/byte assembly).

Parameters:
- SYNC_LEN, 8, decoded SYNC length in bits (SYNC_LEN-1 zeros then a one).
- STUFF_LEN, 6, consecutive decoded ones after which one stuffed zero is removed.
- MAX_BITS, 1100, maximum unstuffed payload bits before a babble error; counter width is $clog2(MAX_BITS+1).

Ports:
- clock  in  1  system clock, one bit time per cycle.
- reset  in  1  asynchronous, active-high reset.
- line_j  in  1  line is in J (idle) state this cycle.
- line_se0  in  1  line is SE0 this cycle; never asserted together with line_j.
- dec_bit  in  1  decoded bit from the NRZI decoder, same cycle.
- dpdm_sending  out  1  to the NRZI decoder: packet in progress.
- bit_out  out  1  unstuffed payload bit.
- bit_valid  out  1  bit_out is valid this cycle.
- pkt_start  out  1  one-cycle pulse: SYNC accepted.
- pkt_end  out  1  one-cycle pulse: valid EOP received.
- rx_err  out  1  one-cycle pulse: sync, stuff, babble or EOP error.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Reset mid-packet aborts immediately with no pkt_end and no rx_err.
- States: IDLE, SYNC, DATA, EOP1, EOP2, WAIT_IDLE.
- dpdm_sending is Moore: 1 in SYNC, DATA, EOP1, EOP2; 0 in IDLE and WAIT_IDLE.
- IDLE: a K (line_j=0, line_se0=0) moves to SYNC. That cycle counts as SYNC bit 1 and is not checked. SE0 in IDLE is ignored.
- SYNC: checks SYNC_LEN-1 further dec_bit values.
  - Expected: SYNC_LEN-2 zeros, then a one.
  - Any mismatch or SE0 -> rx_err pulse, go to WAIT_IDLE.
  - On the final one -> pkt_start pulse (registered, next cycle), go to DATA, ones_cnt=0, bit_cnt=0.
- DATA, each cycle:
  - line_se0 -> EOP1. The SE0 cycle produces no bit.
  - Else if ones_cnt==STUFF_LEN:
    - dec_bit=0: stuffed bit, dropped (bit_valid=0), ones_cnt=0.
    - dec_bit=1: stuff error -> rx_err, WAIT_IDLE.
  - Else: emit bit (bit_out=dec_bit, bit_valid=1 next cycle), bit_cnt+1. ones_cnt is incremented on 1 and cleared on 0.
  - bit_cnt reaching MAX_BITS with another bit pending -> rx_err, WAIT_IDLE.
- EOP1: SE0 -> EOP2; otherwise rx_err, WAIT_IDLE.
- EOP2: J -> pkt_end pulse, IDLE; anything else -> rx_err, WAIT_IDLE.
- WAIT_IDLE: stays until line_j is 1 for 2 consecutive cycles, then IDLE.
- Latency: bit_out, bit_valid, pkt_start, pkt_end and rx_err are registered, 1 cycle after the sampling cycle.
- pkt_end and rx_err are never asserted in the same cycle.
- Zero-bit packet (SE0 immediately after SYNC) is legal: pkt_start then pkt_end, no bit_valid in between.

Optional Feature:
- Macro: USB_RX_BYTE_CHECK_EN
- Defined: in EOP2 on J, if bit_cnt[2:0] != 0, pulse rx_err instead of pkt_end, then go to IDLE.
- Undefined: bit alignment is not checked, and the low bit_cnt bits are unused.

Test Plan:
- J idle, then K J K J K J K K (decoded 0000_0001), data decoded 1010_0101, SE0 SE0 J -> one pkt_start, 8 bit_valid pulses carrying 1,0,1,0,0,1,0,1, then pkt_end; dpdm_sending high from SYNC through EOP2.
- Decoded data 1111_1101 … -> the 0 after six ones is dropped: 7 bit_valid pulses (1,1,1,1,1,1,1), no error.
- Decoded data seven consecutive ones -> rx_err on the seventh, dpdm_sending falls, return to IDLE only after 2 J cycles.
- Corrupt SYNC (decoded 0001_…) -> rx_err, no pkt_start, no bit_valid.
- SE0 then K (bad EOP) -> rx_err, no pkt_end. Separately, reset asserted mid-DATA -> all outputs 0 immediately, state IDLE.
- With USB_RX_BYTE_CHECK_EN, a 5-bit payload then valid EOP -> rx_err, no pkt_end; without the macro -> pkt_end.

Source files
------------

// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: SYNC check, bit unstuffing, EOP detection.
// Optional USB_RX_BYTE_CHECK_EN: flag EOP on a non-byte-aligned payload.
module usb_rx_sequencer #(
    parameter int SYNC_LEN  = 8,
    parameter int STUFF_LEN = 6,
    parameter int MAX_BITS  = 1100
) (
    input  logic clock,
    input  logic reset,
    input  logic line_j,
    input  logic line_se0,
    input  logic dec_bit,
    output logic dpdm_sending,
    output logic bit_out,
    output logic bit_valid,
    output logic pkt_start,
    output logic pkt_end,
    output logic rx_err,
    output logic busy
);

    localparam int BW = $clog2(MAX_BITS + 1);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(SYNC_LEN);

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 2);
    localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
    localparam logic [BW-1:0] BIT_MAX   = BW'(MAX_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP1,
        EOP2,
        WAIT_IDLE
    } state_t;

    state_t          state, state_n;
    logic [SW-1:0]   sync_cnt, sync_cnt_n;
    logic [OW-1:0]   ones_cnt, ones_cnt_n;
    logic [BW-1:0]   bit_cnt, bit_cnt_n;
    logic            j_seen, j_seen_n;
    logic            bit_out_n;
    logic            bit_valid_n;
    logic            pkt_start_n;
    logic            pkt_end_n;
    logic            rx_err_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sync_cnt  <= '0;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            j_seen    <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            pkt_start <= 1'b0;
            pkt_end   <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            state     <= state_n;
            sync_cnt  <= sync_cnt_n;
            ones_cnt  <= ones_cnt_n;
            bit_cnt   <= bit_cnt_n;
            j_seen    <= j_seen_n;
            bit_out   <= bit_out_n;
            bit_valid <= bit_valid_n;
            pkt_start <= pkt_start_n;
            pkt_end   <= pkt_end_n;
            rx_err    <= rx_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        sync_cnt_n  = sync_cnt;
        ones_cnt_n  = ones_cnt;
        bit_cnt_n   = bit_cnt;
        j_seen_n    = 1'b0;
        bit_out_n   = 1'b0;
        bit_valid_n = 1'b0;
        pkt_start_n = 1'b0;
        pkt_end_n   = 1'b0;
        rx_err_n    = 1'b0;

        unique case (state)
            IDLE: begin
                // The first K is SYNC bit 1 and is taken on trust.
                if (!line_j && !line_se0) begin
                    state_n    = SYNC;
                    sync_cnt_n = '0;
                end
            end

            SYNC: begin
                if (line_se0 || (dec_bit != (sync_cnt == SYNC_LAST))) begin
                    rx_err_n = 1'b1;
                    state_n  = WAIT_IDLE;
                end else if (sync_cnt == SYNC_LAST) begin
                    pkt_start_n = 1'b1;
                    state_n     = DATA;
                    ones_cnt_n  = '0;
                    bit_cnt_n   = '0;
                end else begin
                    sync_cnt_n = sync_cnt + SW'(1);
                end
            end

            DATA: begin
                if (line_se0) begin
                    state_n = EOP1;
                end else if (ones_cnt == STUFF_MAX) begin
                    if (dec_bit) begin
                        rx_err_n = 1'b1;
                        state_n  = WAIT_IDLE;
                    end else begin
                        ones_cnt_n = '0;
                    end
                end else if (bit_cnt == BIT_MAX) begin
                    rx_err_n = 1'b1;
                    state_n  = WAIT_IDLE;
                end else begin
                    bit_out_n   = dec_bit;
                    bit_valid_n = 1'b1;
                    bit_cnt_n   = bit_cnt + BW'(1);
                    ones_cnt_n  = dec_bit ? ones_cnt + OW'(1) : '0;
                end
            end

            EOP1: begin
                if (line_se0) begin
                    state_n = EOP2;
                end else begin
                    rx_err_n = 1'b1;
                    state_n  = WAIT_IDLE;
                end
            end

            EOP2: begin
                if (line_j) begin
                    state_n = IDLE;
`ifdef USB_RX_BYTE_CHECK_EN
                    if (bit_cnt[2:0] != 3'd0) begin
                        rx_err_n = 1'b1;
                    end else begin
                        pkt_end_n = 1'b1;
                    end
`else
                    pkt_end_n = 1'b1;
`endif
                end else begin
                    rx_err_n = 1'b1;
                    state_n  = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                // Two back-to-back J samples mean the bus has settled.
                j_seen_n = line_j;
                if (line_j && j_seen) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dpdm_sending = (state == SYNC) || (state == DATA) ||
                          (state == EOP1) || (state == EOP2);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Directed bench for usb_rx_sequencer.
// Drives NRZI-consistent line levels alongside decoded bits.
module tb_usb_rx_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic line_j;
    logic line_se0;
    logic dec_bit;
    logic dpdm_sending;
    logic bit_out;
    logic bit_valid;
    logic pkt_start;
    logic pkt_end;
    logic rx_err;
    logic busy;

    int checks = 0;
    int errors = 0;

    int vcount;
    int start_cnt;
    int end_cnt;
    int err_cnt;
    logic [7:0] vbits;
    logic lvl;

    usb_rx_sequencer dut (
        .clock(clock),
        .reset(reset),
        .line_j(line_j),
        .line_se0(line_se0),
        .dec_bit(dec_bit),
        .dpdm_sending(dpdm_sending),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .pkt_start(pkt_start),
        .pkt_end(pkt_end),
        .rx_err(rx_err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic step(input logic j, input logic se0, input logic d);
        line_j   = j;
        line_se0 = se0;
        dec_bit  = d;
        @(posedge clock);
        #1;
        if (bit_valid) begin
            vcount++;
            vbits = {vbits[6:0], bit_out};
        end
        if (pkt_start) start_cnt++;
        if (pkt_end) end_cnt++;
        if (rx_err) err_cnt++;
    endtask

    task automatic clear_mon();
        vcount    = 0;
        start_cnt = 0;
        end_cnt   = 0;
        err_cnt   = 0;
        vbits     = 8'h00;
    endtask

    task automatic send_bit(input logic d);
        if (!d) lvl = ~lvl;
        step(lvl, 1'b0, d);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        repeat (n) step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        line_j = 1'b1;
        line_se0 = 1'b0;
        dec_bit = 1'b1;
        lvl = 1'b1;
        clear_mon();
        @(posedge clock);
        #1;
        checks++;
        if ({dpdm_sending, bit_out, bit_valid, pkt_start, pkt_end, rx_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 0000000",
                     {dpdm_sending, bit_out, bit_valid, pkt_start, pkt_end, rx_err, busy});
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'b1010_0101;
        idle(3);
        clear_mon();
        send_bit(1'b0);
        checks++;
        if ({dpdm_sending, busy} !== 2'b11) begin
            errors++;
            $display("FAIL basic_sync_enter got %b exp 11", {dpdm_sending, busy});
        end
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if (pkt_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_pkt_start got %b exp 1", pkt_start);
        end
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            checks++;
            if ({bit_valid, bit_out, dpdm_sending} !== {1'b1, pat[i], 1'b1}) begin
                errors++;
                $display("FAIL basic_bit%0d got %b exp %b", 7 - i,
                         {bit_valid, bit_out, dpdm_sending}, {1'b1, pat[i], 1'b1});
            end
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if ({bit_valid, dpdm_sending} !== 2'b01) begin
            errors++;
            $display("FAIL basic_se0 got %b exp 01", {bit_valid, dpdm_sending});
        end
        step(1'b0, 1'b1, 1'b0);
        lvl = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if ({pkt_end, rx_err, dpdm_sending, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_eop got %b exp 1000",
                     {pkt_end, rx_err, dpdm_sending, busy});
        end
        checks++;
        if ({start_cnt, vcount, end_cnt, err_cnt} !== {32'd1, 32'd8, 32'd1, 32'd0} ||
            vbits !== 8'b1010_0101) begin
            errors++;
            $display("FAIL basic_counts got s%0d v%0d e%0d r%0d bits %b exp s1 v8 e1 r0 bits 10100101",
                     start_cnt, vcount, end_cnt, err_cnt, vbits);
        end
    endtask

    task automatic test_stuff();
        idle(2);
        clear_mon();
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if ({bit_valid, rx_err} !== 2'b00) begin
            errors++;
            $display("FAIL stuff_drop got %b exp 00", {bit_valid, rx_err});
        end
        send_bit(1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        lvl = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (vcount !== 7 || vbits[6:0] !== 7'h7F || err_cnt !== 0 || end_cnt !== 1) begin
            errors++;
            $display("FAIL stuff_counts got v%0d bits %b r%0d e%0d exp v7 bits 1111111 r0 e1",
                     vcount, vbits[6:0], err_cnt, end_cnt);
        end
    endtask

    task automatic test_stuff_err();
        idle(2);
        clear_mon();
        send_sync();
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        send_bit(1'b1);
        checks++;
        if ({rx_err, bit_valid, dpdm_sending, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL stuff_err got %b exp 1001",
                     {rx_err, bit_valid, dpdm_sending, busy});
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stuff_wait1 busy got %b exp 1", busy);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stuff_wait2 busy got %b exp 0", busy);
        end
        checks++;
        if (vcount !== 6 || err_cnt !== 1 || end_cnt !== 0) begin
            errors++;
            $display("FAIL stuff_err_counts got v%0d r%0d e%0d exp v6 r1 e0",
                     vcount, err_cnt, end_cnt);
        end
    endtask

    task automatic test_bad_sync();
        idle(2);
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        checks++;
        if ({rx_err, dpdm_sending, busy} !== 3'b101) begin
            errors++;
            $display("FAIL bad_sync got %b exp 101", {rx_err, dpdm_sending, busy});
        end
        idle(2);
        checks++;
        if (start_cnt !== 0 || vcount !== 0 || err_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_sync_counts got s%0d v%0d r%0d busy %b exp s0 v0 r1 busy 0",
                     start_cnt, vcount, err_cnt, busy);
        end
    endtask

    task automatic test_bad_eop();
        idle(2);
        clear_mon();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if ({rx_err, pkt_end} !== 2'b10) begin
            errors++;
            $display("FAIL bad_eop got %b exp 10", {rx_err, pkt_end});
        end
        idle(2);
        checks++;
        if (end_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_eop_after got e%0d busy %b exp e0 busy 0", end_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        idle(2);
        clear_mon();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got %b exp 1", bit_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dpdm_sending, bit_out, bit_valid, pkt_start, pkt_end, rx_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset got %b exp 0000000",
                     {dpdm_sending, bit_out, bit_valid, pkt_start, pkt_end, rx_err, busy});
        end
        step(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        idle(2);
        checks++;
        if (err_cnt !== 0 || end_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after got r%0d e%0d busy %b exp r0 e0 busy 0",
                     err_cnt, end_cnt, busy);
        end
    endtask

    task automatic test_zero_bit();
        idle(2);
        clear_mon();
        send_sync();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        lvl = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (pkt_end !== 1'b1 || start_cnt !== 1 || vcount !== 0 || err_cnt !== 0) begin
            errors++;
            $display("FAIL zero_bit got end %b s%0d v%0d r%0d exp end 1 s1 v0 r0",
                     pkt_end, start_cnt, vcount, err_cnt);
        end
    endtask

    task automatic test_byte_check();
        logic [4:0] pat;
        pat = 5'b10110;
        idle(2);
        clear_mon();
        send_sync();
        for (int i = 4; i >= 0; i--) send_bit(pat[i]);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        lvl = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        checks++;
`ifdef USB_RX_BYTE_CHECK_EN
        if ({rx_err, pkt_end, busy} !== 3'b100) begin
            errors++;
            $display("FAIL byte_check got %b exp 100", {rx_err, pkt_end, busy});
        end
`else
        if ({rx_err, pkt_end, busy} !== 3'b010) begin
            errors++;
            $display("FAIL byte_check got %b exp 010", {rx_err, pkt_end, busy});
        end
`endif
        checks++;
        if (vcount !== 5 || vbits[4:0] !== 5'b10110) begin
            errors++;
            $display("FAIL byte_bits got v%0d bits %b exp v5 bits 10110", vcount, vbits[4:0]);
        end
    endtask

    task automatic test_babble();
        idle(2);
        clear_mon();
        send_sync();
        repeat (1100) send_bit(1'b0);
        checks++;
        if (vcount !== 1100 || err_cnt !== 0) begin
            errors++;
            $display("FAIL babble_fill got v%0d r%0d exp v1100 r0", vcount, err_cnt);
        end
        send_bit(1'b0);
        checks++;
        if ({rx_err, bit_valid, dpdm_sending} !== 3'b100) begin
            errors++;
            $display("FAIL babble_err got %b exp 100", {rx_err, bit_valid, dpdm_sending});
        end
        idle(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL babble_idle busy got %b exp 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuff();
        test_stuff_err();
        test_bad_sync();
        test_bad_eop();
        test_reset_mid();
        test_zero_bit();
        test_byte_check();
        test_babble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
